// File: rtl/arbitro_pops_nvc.sv
// Pop arbiter for NUM_VC FWFT virtual channels onto NUM_DEST destination FIFOs.
// Strict priority or weighted round robin with per-destination backpressure.
module arbitro_pops_nvc #(
    parameter int NUM_VC   = 4,
    parameter int NUM_DEST = 4,
    parameter int DATA_W   = 6,
    parameter int WEIGHT_W = 4,
    parameter int DEST_W   = $clog2(NUM_DEST)
) (
    input  logic                         clk,
    input  logic                         reset_L,
    input  logic [NUM_VC-1:0]            vc_empty,
    input  logic [NUM_VC*DATA_W-1:0]     vc_head,
    input  logic [NUM_DEST-1:0]          dest_full,
    input  logic [NUM_DEST-1:0]          dest_almost_full,
    input  logic                         mode,
    input  logic [NUM_VC*WEIGHT_W-1:0]   weights,
    output logic [NUM_VC-1:0]            vc_pop,
    output logic [NUM_VC-1:0]            pop_delay,
    output logic [NUM_DEST-1:0]          dest_push,
    output logic [$clog2(NUM_VC)-1:0]    grant_vc
);

    localparam int VC_W = $clog2(NUM_VC);
    localparam int DPAD = 1 << DEST_W;

    logic [DEST_W-1:0]   dest [NUM_VC];
    logic [DPAD-1:0]     blocked;
    logic [DPAD-1:0]     dvalid;
    logic [NUM_VC-1:0]   elig;
    logic [VC_W-1:0]     owner;
    logic [WEIGHT_W-1:0] credit;
    logic                grant_hit;
    logic [VC_W-1:0]     grant_idx;
    logic [VC_W-1:0]     next_owner;
    logic [WEIGHT_W-1:0] next_credit;
    logic [WEIGHT_W-1:0] w_sel;
    logic [DEST_W-1:0]   g_dest;
    logic [NUM_DEST-1:0] push_nxt;

    // Padded views so out-of-range destination codes index safely.
    always_comb begin
        blocked = '0;
        dvalid  = '0;
        blocked[NUM_DEST-1:0] = dest_full | dest_almost_full;
        dvalid[NUM_DEST-1:0]  = '1;
        for (int i = 0; i < NUM_VC; i++) begin
            dest[i] = vc_head[i*DATA_W + DATA_W - DEST_W +: DEST_W];
            elig[i] = ~vc_empty[i] & dvalid[dest[i]] & ~blocked[dest[i]];
        end
    end

    always_comb begin
        int idx;
        grant_hit   = 1'b0;
        grant_idx   = '0;
        next_owner  = owner;
        next_credit = credit;
        w_sel       = '0;
        idx         = 0;
        if (!mode) begin
            next_owner  = VC_W'(NUM_VC - 1);
            next_credit = '0;
            for (int i = NUM_VC - 1; i >= 0; i--) begin
                if (elig[i]) begin
                    grant_hit = 1'b1;
                    grant_idx = VC_W'(i);
                end
            end
        end else if (elig[owner] && credit != '0) begin
            grant_hit   = 1'b1;
            grant_idx   = owner;
            next_credit = credit - 1'b1;
        end else begin
            // Descending scan so the nearest VC after owner wins.
            for (int k = NUM_VC; k >= 1; k--) begin
                idx = (int'(owner) + k) % NUM_VC;
                if (elig[idx[VC_W-1:0]]) begin
                    grant_hit = 1'b1;
                    grant_idx = idx[VC_W-1:0];
                end
            end
            if (grant_hit) begin
                for (int i = 0; i < NUM_VC; i++) begin
                    if (grant_idx == VC_W'(i)) begin
                        w_sel = weights[i*WEIGHT_W +: WEIGHT_W];
                    end
                end
                next_owner  = grant_idx;
                next_credit = (w_sel == '0) ? '0 : w_sel - 1'b1;
            end
        end
    end

    always_comb begin
        g_dest = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            vc_pop[i] = reset_L & grant_hit & (grant_idx == VC_W'(i));
            if (grant_idx == VC_W'(i)) begin
                g_dest = dest[i];
            end
        end
        for (int j = 0; j < NUM_DEST; j++) begin
            push_nxt[j] = (g_dest == DEST_W'(j));
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            pop_delay <= '0;
            dest_push <= '0;
            grant_vc  <= '0;
            owner     <= VC_W'(NUM_VC - 1);
            credit    <= '0;
        end else begin
            pop_delay <= vc_pop;
            owner     <= next_owner;
            credit    <= next_credit;
            if (grant_hit) begin
                dest_push <= push_nxt;
                grant_vc  <= grant_idx;
            end else begin
                dest_push <= '0;
            end
        end
    end

endmodule
